chu_debounce_btn: RTL and testbench

CHU_DEBOUNCE_BTN -- requirements
Module: chu_debounce_btn

---
 rtl/chu_debounce_btn.sv | 133 +++++++++++++
 tb/tb_chu_debounce_btn.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/chu_debounce_btn.sv
// Debounced push-button slot: synchronizes W raw inputs, filters each through a
// tick-paced debounce FSM and exposes level, sticky rising-edge and raw views on the bus.
module chu_debounce_btn #(
   parameter logic isSimulation = 1'b0,
   parameter int   W            = 4,
   parameter int   DB_MS        = 20
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cs,
   input  logic          read,
   input  logic          write,
   input  logic [4:0]    addr,
   input  logic [31:0]   wr_data,
   output logic [31:0]   rd_data,
   input  logic [W-1:0]  din
);
   localparam int TICK_PERIOD = isSimulation ? 10 : 100_000;
   localparam int TW          = $clog2(TICK_PERIOD);
   localparam int CW          = ($clog2(DB_MS + 1) > 0) ? $clog2(DB_MS + 1) : 1;

   typedef enum logic [1:0] {S0, W1, S1, W0} state_e;

   logic [TW-1:0] tick_cnt_q;
   logic          tick;
   logic [W-1:0]  sync1_q;
   logic [W-1:0]  sync2_q;
   logic [W-1:0]  level;
   logic [W-1:0]  edge_bits;
   logic [W-1:0]  clr;
   logic          unused_inputs;

   assign unused_inputs = ^{read, addr[4:2], wr_data};

   assign tick = (tick_cnt_q == TW'(TICK_PERIOD - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tick_cnt_q <= '0;
      end else if (tick) begin
         tick_cnt_q <= '0;
      end else begin
         tick_cnt_q <= tick_cnt_q + TW'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= din;
         sync2_q <= sync1_q;
      end
   end

   assign clr = (cs && write && (addr[1:0] == 2'd1)) ? wr_data[W-1:0] : '0;

   for (genvar gi = 0; gi < W; gi++) begin : g_bit
      state_e        state_q;
      logic [CW-1:0] cnt_q;
      logic          level_q;
      logic          edge_q;

      // A level change needs DB_MS+1 ticks of uninterrupted disagreement, so any
      // pulse shorter than DB_MS full tick periods can never get through.
      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            state_q <= S0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            edge_q  <= 1'b0;
         end else begin
            edge_q <= edge_q & ~clr[gi];
            case (state_q)
               S0: begin
                  if (sync2_q[gi]) state_q <= W1;
               end
               W1: begin
                  if (!sync2_q[gi]) begin
                     state_q <= S0;
                     cnt_q   <= '0;
                  end else if (tick) begin
                     if (cnt_q == CW'(DB_MS)) begin
                        state_q <= S1;
                        cnt_q   <= '0;
                        level_q <= 1'b1;
                        edge_q  <= 1'b1;
                     end else begin
                        cnt_q <= cnt_q + CW'(1);
                     end
                  end
               end
               S1: begin
                  if (!sync2_q[gi]) state_q <= W0;
               end
               W0: begin
                  if (sync2_q[gi]) begin
                     state_q <= S1;
                     cnt_q   <= '0;
                  end else if (tick) begin
                     if (cnt_q == CW'(DB_MS)) begin
                        state_q <= S0;
                        cnt_q   <= '0;
                        level_q <= 1'b0;
                     end else begin
                        cnt_q <= cnt_q + CW'(1);
                     end
                  end
               end
               default: begin
                  state_q <= S0;
                  cnt_q   <= '0;
               end
            endcase
         end
      end

      assign level[gi]     = level_q;
      assign edge_bits[gi] = edge_q;
   end

   always_comb begin
      rd_data = '0;
      case (addr[1:0])
         2'd0:    rd_data[W-1:0] = level;
         2'd1:    rd_data[W-1:0] = edge_bits;
         2'd2:    rd_data[W-1:0] = sync2_q;
         default: rd_data = '0;
      endcase
   end

endmodule

// File: tb/tb_chu_debounce_btn.sv
// Scoreboard bench for chu_debounce_btn: a behavioural model predicts each read,
// a negedge monitor pops predictions whenever read is asserted and compares.
module tb_chu_debounce_btn;
   localparam int W      = 4;
   localparam int DB_MS  = 2;
   localparam int PERIOD = 10;

   logic        clk     = 1'b0;
   logic        reset   = 1'b0;
   logic        cs      = 1'b0;
   logic        read    = 1'b0;
   logic        write   = 1'b0;
   logic [4:0]  addr    = '0;
   logic [31:0] wr_data = '0;
   logic [31:0] rd_data;
   logic [W-1:0] din    = '0;

   chu_debounce_btn #(.isSimulation(1'b1), .W(W), .DB_MS(DB_MS)) dut (
      .clk(clk), .reset(reset), .cs(cs), .read(read), .write(write),
      .addr(addr), .wr_data(wr_data), .rd_data(rd_data), .din(din)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  a;
      logic [31:0] exp;
      int          ph;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;

   // Reference model: a bit's level flips once the synchronized input has
   // disagreed with it across more than DB_MS ticks, counted from the cycle
   // after the disagreement is first seen.
   logic [W-1:0] m_s1, m_s2, m_level, m_edge;
   int           m_ticks[W];
   bit           m_wait[W];
   int           m_k;

   function automatic string pname(input int p);
      case (p)
         0: return "reset_hold";
         1: return "post_release";
         2: return "clean_press";
         3: return "glitch";
         4: return "w1c";
         5: return "set_wins";
         6: return "rst_midwait";
         7: return "after_rst";
         default: return "random";
      endcase
   endfunction

   task automatic model_reset();
      m_s1 = '0; m_s2 = '0; m_level = '0; m_edge = '0; m_k = 0;
      for (int b = 0; b < W; b++) begin
         m_ticks[b] = 0;
         m_wait[b]  = 1'b0;
      end
   endtask

   task automatic model_step();
      logic [W-1:0] clr;
      bit           tick_now;
      tick_now = ((m_k % PERIOD) == PERIOD - 1);
      m_k++;
      clr = (cs && write && addr[1:0] == 2'd1) ? wr_data[W-1:0] : '0;
      m_edge = m_edge & ~clr;
      for (int b = 0; b < W; b++) begin
         if (m_s2[b] != m_level[b]) begin
            if (!m_wait[b]) begin
               m_wait[b] = 1'b1;
            end else if (tick_now) begin
               m_ticks[b]++;
               if (m_ticks[b] > DB_MS) begin
                  m_level[b] = ~m_level[b];
                  if (m_level[b]) m_edge[b] = 1'b1;
                  m_wait[b]  = 1'b0;
                  m_ticks[b] = 0;
               end
            end
         end else begin
            m_wait[b]  = 1'b0;
            m_ticks[b] = 0;
         end
      end
      m_s2 = m_s1;
      m_s1 = din;
   endtask

   function automatic logic [31:0] model_read(input logic [4:0] a);
      logic [31:0] v;
      v = '0;
      case (a[1:0])
         2'd0:    v[W-1:0] = m_level;
         2'd1:    v[W-1:0] = m_edge;
         2'd2:    v[W-1:0] = m_s2;
         default: v = '0;
      endcase
      return v;
   endfunction

   task automatic tick_model();
      @(posedge clk);
      if (!reset) model_reset();
      else model_step();
   endtask

   task automatic apply(input logic [W-1:0] d, input logic [4:0] a, input logic c,
                        input logic wr, input logic [31:0] wd, input logic rd,
                        input logic rst, input int ph);
      #1;
      din = d; addr = a; cs = c; write = wr; wr_data = wd; read = rd; reset = rst;
      if (!rst) model_reset();
      if (rd) sb_q.push_back('{a, model_read(a), ph});
   endtask

   task automatic step(input logic [W-1:0] d, input logic [4:0] a, input logic c,
                       input logic wr, input logic [31:0] wd, input logic rd,
                       input logic rst, input int ph);
      tick_model();
      apply(d, a, c, wr, wd, rd, rst, ph);
   endtask

   always @(negedge clk) begin
      if (read) begin
         checks++;
         if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL sb_underflow: read seen with no prediction, rd_data=%h", rd_data);
         end else begin
            mon_e = sb_q.pop_front();
            if (rd_data !== mon_e.exp) begin
               errors++;
               $display("FAIL %s addr=%0d got=%h exp=%h", pname(mon_e.ph), mon_e.a, rd_data, mon_e.exp);
            end else begin
               $display("chk %0d %s addr=%0d rd=%h", checks, pname(mon_e.ph), mon_e.a, rd_data);
            end
         end
      end
   end

   initial begin
      logic [W-1:0] d;
      logic         rst_v;
      logic         wr_v;
      int           n_wait;

      model_reset();

      for (int i = 0; i < 8; i++) step(4'hF, 5'(i % 4), 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 0);
      for (int i = 0; i < 8; i++) step(4'h0, 5'(i % 4), 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1);

      for (int i = 0; i < 100; i++) step(4'h1, 5'(i % 3), 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 2);
      for (int i = 0; i < 45; i++)  step(4'h0, 5'(i % 3), 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 2);

      for (int i = 0; i < 15; i++) step(4'h2, 5'(i % 3), 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 3);
      for (int i = 0; i < 40; i++) step(4'h0, 5'(i % 3), 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 3);

      for (int i = 0; i < 45; i++) step(4'h2, 5'(i % 2), 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 4);
      for (int i = 0; i < 45; i++) step(4'h0, 5'(i % 2), 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 4);
      step(4'h0, 5'd1, 1'b1, 1'b1, 32'h1, 1'b1, 1'b1, 4);
      step(4'h0, 5'd1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 4);
      step(4'h0, 5'd0, 1'b1, 1'b1, 32'hF, 1'b1, 1'b1, 4);
      step(4'h0, 5'd1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 4);
      step(4'h0, 5'd1, 1'b0, 1'b1, 32'hF, 1'b1, 1'b1, 4);
      step(4'h0, 5'd1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 4);
      step(4'h0, 5'd3, 1'b1, 1'b1, 32'hF, 1'b1, 1'b1, 4);
      step(4'h0, 5'd1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 4);

      // Keep clearing bit 2 right up to the cycle its edge is set.
      n_wait = 0;
      while (1) begin
         tick_model();
         if (m_edge[2] || n_wait >= 80) break;
         apply(4'h4, 5'd1, 1'b1, 1'b1, 32'h4, 1'b1, 1'b1, 5);
         n_wait++;
      end
      apply(4'h4, 5'd1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 5);
      for (int i = 0; i < 5; i++) step(4'h4, 5'd1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 5);

      n_wait = 0;
      do begin
         step(4'hC, 5'd0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 6);
         n_wait++;
      end while (!m_wait[3] && n_wait < 20);
      step(4'hC, 5'd0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 6);
      for (int i = 0; i < 45; i++) step(4'hC, 5'(i % 4 == 3 ? 1 : 0), 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 7);

      for (int n = 0; n < 1500; n++) begin
         tick_model();
         d = din;
         for (int b = 0; b < W; b++) if ($urandom_range(29) == 0) d[b] = ~d[b];
         rst_v = ($urandom_range(499) != 0);
         wr_v  = ($urandom_range(7) == 0);
         apply(d, 5'($urandom), 1'($urandom), wr_v, $urandom,
               1'($urandom_range(3) != 0), rst_v, 8);
      end

      tick_model();
      apply(4'h0, 5'd0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 8);
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL sb_drain: %0d predictions left, required 0", sb_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
